decodec_pipe: RTL and testbench
===============================

# decodec_pipe

Parametrised, pipelined successor to the instruction decoder. It accepts one instruction word per cycle over a valid/ready handshake and decodes it into datapath selects, enables and immediate/address fields. It resolves conditional branches against two flag banks and squashes a configurable number of wrong-path instructions after every taken control transfer. It sits between instruction fetch and the register/ALU stage.

## Interface
- `IW`, 16: instruction width; opcode is `in[IW-1 -: 6]`; field width `AW = IW-6` (≥10).
- `NF`, 3: flags per bank.
- `SQUASH`, 1: instructions dropped after a taken jump/branch (0..7).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  IW  instruction word.
- `inValid` / `inReady`  in / out  1  input handshake.
- `flagA`, `flagB`  in  NF  flag banks, sampled on input acceptance.
- `outValid` / `outReady`  out / in  1  output handshake.
- `opCode`  out  6; `selA`, `selB`  out  2; `selM1`, `selM2`, `wrEnable`, `jmpEnable`, `branchEnable`  out  1.
- `inm`  out  8 = `in[7:0]`; `memDir`  out  10 = `in[9:0]`; `jmpDir`  out  AW = `in[AW-1:0]`; `branchDir`  out  6 = `in[5:0]`.
- `illegal`  out  1  (only with `DECODEC_TRAP_EN`).

## Operation
- Class = `opCode[5:4]`:
  - 00 ALU-reg: `wrEnable`=1, `selM1`=0, `selA`=`opCode[3:2]`, `selB`=`opCode[1:0]`.
  - 01 ALU-imm: `wrEnable`=1, `selM1`=1, `selA`=`opCode[3:2]`.
  - 10 memory: `opCode[3]`=1 is load (`selM2`=1, `wrEnable`=1); `opCode[3]`=0 is store (`wrEnable`=0).
  - 11 control, by `opCode[3:2]`:
    - 00 JMP: `jmpEnable`=1.
    - 01 branch on `flagA[opCode[1:0]]`; 10 branch on `flagB[opCode[1:0]]`. `branchEnable` is the sampled flag bit.
    - 11 NOP.
- Selects and enables not listed for a class are 0.
- Illegal encodings:
  - Branch bit index ≥ NF.
  - Control-class NOP with `opCode[1:0]`≠0.
- Handling of illegal encodings: all enables are forced to 0, and `illegal`=1 when the macro is compiled in.
- Squash FSM, states RUN and SQUASH:
  - RUN → SQUASH when an instruction with `jmpEnable` or `branchEnable` set is accepted, and `SQUASH`>0. The counter loads `SQUASH`.
  - In SQUASH, each accepted instruction is discarded and the counter decrements. The FSM returns to RUN when the counter reaches 0.
  - Discarded instructions never raise `outValid`.
  - A not-taken branch does not enter SQUASH.

## Timing
- Latency: 1 cycle from an accepted input to `outValid`, with registered outputs.
- Throughput: 1 instruction per cycle while `outReady`=1.
- Input side uses a 2-entry skid buffer:
  - `inReady` is registered.
  - `inReady` deasserts only when both entries are full.
  - No instruction is lost or duplicated under any `outReady` pattern.
- Outputs hold stable while `outValid`=1 and `outReady`=0.
- Reset (asynchronous assert, synchronous release):
  - All outputs 0, `inReady`=0 during reset.
  - `inReady`=1 on the first cycle after release.
  - FSM is RUN, counter is 0, skid is empty.
- Reset asserted mid-squash or with full skid: all in-flight state is discarded.
- Flags are captured together with `in` on the accepting edge. Later flag changes do not affect a buffered instruction.
- Simultaneous events:
  - Accepting a taken branch while in SQUASH: the branch is itself squashed, and the counter is not reloaded.
  - Accept and output on the same cycle with skid at 1 entry: occupancy is unchanged.

## Configuration
- `DECODEC_TRAP_EN`:
  - Defined: `illegal` port exists, is registered with the other outputs, and is cleared on reset.
  - Undefined: no `illegal` port. Illegal encodings still decode with all enables 0.

## Structure
- Package `decodec_pkg`: class codes, control sub-codes, and field widths (6-bit opcode, 8-bit `inm`, 10-bit `memDir`, 6-bit `branchDir`).
- Sub-module `decodec_skid`: parametrised 2-entry skid buffer carrying `{in, flagA, flagB}`.
- Decode logic and the squash FSM live in the top module.

## Test plan
- Reset then ALU-reg: `in`=16'b000110_0000000000 → next cycle `outValid`=1, `wrEnable`=1, `selA`=01, `selB`=10, other enables 0.
- JMP: `in`={6'b110000, 10'h155}, `SQUASH`=1, followed by 16'h0400 → `jmpEnable`=1, `jmpDir`=10'h155; the following instruction is dropped (`outValid` stays 0 for it).
- Branch taken vs not: opcode 110101 (flagA bit 1):
  - `flagA`=3'b010 → `branchEnable`=1 and the next instruction is squashed.
  - `flagA`=3'b000 → `branchEnable`=0, no squash.
- Backpressure: stream 6 instructions with `outReady` toggling 1,0,0,1 → `inReady` falls after two stalled accepts; all 6 emerge in order, exactly once.
- Illegal: opcode 110111 with `DECODEC_TRAP_EN` → `illegal`=1, all enables 0; rerun without the macro → same enables.
- Reset mid-squash: assert `reset`=0 while the counter is 1 → outputs 0 immediately; after release, the next instruction is output normally.

Source files
------------

// File: rtl/decodec_pkg.sv
// decodec_pkg: shared types and field widths for the pipelined instruction
// decoder (decodec_pipe) and its bus interfaces.
//   - instruction class / control sub-code encodings (opCode[5:4], opCode[3:2])
//   - squash FSM state encoding
//   - fixed output field widths (opcode, inm, memDir, branchDir)
//   - dec_t: the registered select/enable bundle
package decodec_pkg;

    localparam int OPC_W  = 6;
    localparam int INM_W  = 8;
    localparam int MEM_W  = 10;
    localparam int BDIR_W = 6;

    typedef enum logic [1:0] {
        CLS_ALU_REG = 2'b00,
        CLS_ALU_IMM = 2'b01,
        CLS_MEM     = 2'b10,
        CLS_CTRL    = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        CTL_JMP = 2'b00,
        CTL_BRA = 2'b01,
        CTL_BRB = 2'b10,
        CTL_NOP = 2'b11
    } ctl_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } sq_state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [1:0]       sel_a;
        logic [1:0]       sel_b;
        logic             sel_m1;
        logic             sel_m2;
        logic             wr_en;
        logic             jmp_en;
        logic             br_en;
    } dec_t;

endpackage

// File: rtl/decodec_if.sv
// Bus interfaces of decodec_pipe.
//   decodec_in_if  : fetch -> decoder. in, inValid, flagA, flagB (master drives),
//                    inReady (slave drives).
//   decodec_out_if : decoder -> register/ALU stage. outValid plus all decoded
//                    fields (master drives), outReady (slave drives).
// Optional feature macro: DECODEC_TRAP_EN adds the `illegal` output signal.
interface decodec_in_if #(
    parameter int IW = 16,
    parameter int NF = 3
);
    logic [IW-1:0] in;
    logic          inValid;
    logic          inReady;
    logic [NF-1:0] flagA;
    logic [NF-1:0] flagB;

    modport master (output in, inValid, flagA, flagB, input inReady);
    modport slave  (input in, inValid, flagA, flagB, output inReady);
endinterface

interface decodec_out_if
    import decodec_pkg::*;
#(
    parameter int IW = 16
);
    localparam int AW = IW - OPC_W;

    logic              outValid;
    logic              outReady;
    logic [OPC_W-1:0]  opCode;
    logic [1:0]        selA;
    logic [1:0]        selB;
    logic              selM1;
    logic              selM2;
    logic              wrEnable;
    logic              jmpEnable;
    logic              branchEnable;
    logic [INM_W-1:0]  inm;
    logic [MEM_W-1:0]  memDir;
    logic [AW-1:0]     jmpDir;
    logic [BDIR_W-1:0] branchDir;
`ifdef DECODEC_TRAP_EN
    logic              illegal;

    modport master (output outValid, opCode, selA, selB, selM1, selM2, wrEnable,
                     jmpEnable, branchEnable, inm, memDir, jmpDir, branchDir, illegal,
                     input outReady);
    modport slave  (input outValid, opCode, selA, selB, selM1, selM2, wrEnable,
                     jmpEnable, branchEnable, inm, memDir, jmpDir, branchDir, illegal,
                     output outReady);
`else
    modport master (output outValid, opCode, selA, selB, selM1, selM2, wrEnable,
                     jmpEnable, branchEnable, inm, memDir, jmpDir, branchDir,
                     input outReady);
    modport slave  (input outValid, opCode, selA, selB, selM1, selM2, wrEnable,
                     jmpEnable, branchEnable, inm, memDir, jmpDir, branchDir,
                     output outReady);
`endif
endinterface

// File: rtl/decodec_skid.sv
// decodec_skid: 2-entry skid buffer with fall-through.
//   clk, reset (async, active-low)
//   wr_data/wr_valid/wr_ready : upstream side; wr_ready is registered and only
//                               drops when both entries are occupied
//   rd_data/rd_valid          : head of buffer (or the incoming word when empty)
//   rd_take                   : consumer takes the head this cycle if rd_valid
module decodec_skid #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_take
);
    logic [W-1:0] mem_q [0:1];
    logic [W-1:0] mem_d [0:1];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         push, pop, stored;

    assign wr_ready = ready_q;
    assign push     = wr_valid && ready_q;
    assign stored   = (cnt_q != 2'd0);
    // Empty buffer passes the incoming word straight through so the decoder
    // sees it in the same cycle (keeps latency at one register stage).
    assign rd_valid = stored || push;
    assign rd_data  = stored ? mem_q[rd_ptr_q] : wr_data;
    assign pop      = rd_take && rd_valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // A push consumed in the same cycle on an empty buffer never lands.
        if (push && !(pop && !stored)) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop && stored) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/decodec_pipe.sv
// decodec_pipe: pipelined instruction decoder with branch resolution and
// wrong-path squash.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   up    : decodec_in_if.slave  (in, inValid, inReady, flagA, flagB)
//   dn    : decodec_out_if.master (outValid/outReady and decoded fields)
// Parameters: IW instruction width, NF flags per bank, SQUASH instructions
// dropped after a taken jump/branch (0..7).
// Optional macro DECODEC_TRAP_EN: registers and drives dn.illegal.
module decodec_pipe
    import decodec_pkg::*;
#(
    parameter int IW     = 16,
    parameter int NF     = 3,
    parameter int SQUASH = 1
) (
    input logic           clk,
    input logic           reset,
    decodec_in_if.slave   up,
    decodec_out_if.master dn
);
    localparam int         AW      = IW - OPC_W;
    localparam int         SW      = IW + 2 * NF;
    localparam logic [2:0] SQ_LOAD = 3'(SQUASH);

    logic [SW-1:0] head;
    logic          head_valid, skid_ready, take, pop, squashing, out_free;
    logic [IW-1:0] h_in;
    logic [NF-1:0] h_fa, h_fb;

    // Flags travel with the instruction so later flag changes cannot affect it.
    decodec_skid #(.W(SW)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr_data  ({up.in, up.flagA, up.flagB}),
        .wr_valid (up.inValid),
        .wr_ready (skid_ready),
        .rd_data  (head),
        .rd_valid (head_valid),
        .rd_take  (take)
    );
    assign up.inReady = skid_ready;
    assign {h_in, h_fa, h_fb} = head;

    logic [OPC_W-1:0] opc;
    dec_t             dec;
    logic             illegal, idx_ok, bit_a, bit_b;

    always_comb begin
        opc     = h_in[IW-1 -: OPC_W];
        dec     = '0;
        illegal = 1'b0;
        idx_ok  = 1'b0;
        bit_a   = 1'b0;
        bit_b   = 1'b0;
        dec.opcode = opc;
        for (int i = 0; i < NF; i++) begin
            if (int'(opc[1:0]) == i) begin
                idx_ok = 1'b1;
                bit_a  = h_fa[i];
                bit_b  = h_fb[i];
            end
        end
        case (cls_e'(opc[5:4]))
            CLS_ALU_REG: begin
                dec.wr_en = 1'b1;
                dec.sel_a = opc[3:2];
                dec.sel_b = opc[1:0];
            end
            CLS_ALU_IMM: begin
                dec.wr_en  = 1'b1;
                dec.sel_m1 = 1'b1;
                dec.sel_a  = opc[3:2];
            end
            CLS_MEM: begin
                dec.sel_m2 = opc[3];
                dec.wr_en  = opc[3];
            end
            CLS_CTRL: begin
                case (ctl_e'(opc[3:2]))
                    CTL_JMP: dec.jmp_en = 1'b1;
                    CTL_BRA: begin
                        illegal    = !idx_ok;
                        dec.br_en  = bit_a;
                    end
                    CTL_BRB: begin
                        illegal    = !idx_ok;
                        dec.br_en  = bit_b;
                    end
                    CTL_NOP: illegal = (opc[1:0] != 2'b00);
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (illegal) begin
            dec.wr_en  = 1'b0;
            dec.jmp_en = 1'b0;
            dec.br_en  = 1'b0;
            dec.sel_m1 = 1'b0;
            dec.sel_m2 = 1'b0;
        end
    end

    sq_state_e     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    dec_t          dec_q, dec_d;
    logic [AW-1:0] field_q, field_d;
`ifdef DECODEC_TRAP_EN
    logic          illegal_q, illegal_d;
`endif

    assign squashing = (state_q == ST_SQUASH);
    assign out_free  = !out_valid_q || dn.outReady;
    // Discards need no output slot, so squashing drains even under backpressure.
    assign take      = squashing || out_free;
    assign pop       = take && head_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        dec_d       = dec_q;
        field_d     = field_q;
`ifdef DECODEC_TRAP_EN
        illegal_d   = illegal_q;
`endif
        if (pop && squashing) begin
            // A taken transfer arriving here is dropped and does not reload.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = ST_RUN;
            end
        end else if (pop && (dec.jmp_en || dec.br_en) && (SQUASH > 0)) begin
            state_d = ST_SQUASH;
            cnt_d   = SQ_LOAD;
        end
        if (out_free) begin
            out_valid_d = pop && !squashing;
            if (pop && !squashing) begin
                dec_d   = dec;
                field_d = h_in[AW-1:0];
`ifdef DECODEC_TRAP_EN
                illegal_d = illegal;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 3'd0;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            field_q     <= '0;
`ifdef DECODEC_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
            field_q     <= field_d;
`ifdef DECODEC_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign dn.outValid     = out_valid_q;
    assign dn.opCode       = dec_q.opcode;
    assign dn.selA         = dec_q.sel_a;
    assign dn.selB         = dec_q.sel_b;
    assign dn.selM1        = dec_q.sel_m1;
    assign dn.selM2        = dec_q.sel_m2;
    assign dn.wrEnable     = dec_q.wr_en;
    assign dn.jmpEnable    = dec_q.jmp_en;
    assign dn.branchEnable = dec_q.br_en;
    assign dn.inm          = field_q[INM_W-1:0];
    assign dn.memDir       = field_q[MEM_W-1:0];
    assign dn.jmpDir       = field_q;
    assign dn.branchDir    = field_q[BDIR_W-1:0];
`ifdef DECODEC_TRAP_EN
    assign dn.illegal      = illegal_q;
`endif
endmodule

// File: tb/tb_decodec_pipe.sv
// Directed testbench for decodec_pipe (IW=16, NF=3, SQUASH=1).
module tb_decodec_pipe;
    logic       clk;
    logic       reset;
    int         total;
    int         bad;
    int         tx;
    int         rx;
    logic       saw_stall;
    logic [3:0] pat;

    decodec_in_if  #(.IW(16), .NF(3)) up_if ();
    decodec_out_if #(.IW(16))         dn_if ();

    decodec_pipe #(.IW(16), .NF(3), .SQUASH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .up    (up_if.slave),
        .dn    (dn_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tx    = 0;
        rx    = 0;
        saw_stall = 1'b0;
        pat   = 4'b1001;
        reset = 1'b0;
        up_if.in      = '0;
        up_if.inValid = 1'b0;
        up_if.flagA   = '0;
        up_if.flagB   = '0;
        dn_if.outReady = 1'b1;

        // reset state
        step();
        step();
        chk("rst_inReady", up_if.inReady, 0);
        chk("rst_outValid", dn_if.outValid, 0);
        chk("rst_wrEnable", dn_if.wrEnable, 0);
        reset = 1'b1;
        step();
        chk("rel_inReady", up_if.inReady, 1);
        chk("rel_outValid", dn_if.outValid, 0);

        // ALU-reg
        up_if.in = 16'b000110_0000000000;
        up_if.inValid = 1'b1;
        step();
        up_if.inValid = 1'b0;
        chk("alu_valid", dn_if.outValid, 1);
        chk("alu_wr", dn_if.wrEnable, 1);
        chk("alu_selA", dn_if.selA, 2'b01);
        chk("alu_selB", dn_if.selB, 2'b10);
        chk("alu_selM1", dn_if.selM1, 0);
        chk("alu_jmp", dn_if.jmpEnable, 0);
        chk("alu_br", dn_if.branchEnable, 0);
        chk("alu_opc", dn_if.opCode, 6'b000110);
        step();
        chk("alu_drain", dn_if.outValid, 0);

        // memory load then store
        up_if.in = {6'b101000, 10'h3C4};
        up_if.inValid = 1'b1;
        step();
        up_if.in = {6'b100000, 10'h011};
        chk("ld_selM2", dn_if.selM2, 1);
        chk("ld_wr", dn_if.wrEnable, 1);
        chk("ld_memDir", dn_if.memDir, 10'h3C4);
        step();
        up_if.inValid = 1'b0;
        chk("st_valid", dn_if.outValid, 1);
        chk("st_wr", dn_if.wrEnable, 0);
        chk("st_selM2", dn_if.selM2, 0);
        step();

        // JMP squashes exactly one follower
        up_if.in = {6'b110000, 10'h155};
        up_if.inValid = 1'b1;
        step();
        up_if.in = 16'h0400;
        chk("jmp_valid", dn_if.outValid, 1);
        chk("jmp_en", dn_if.jmpEnable, 1);
        chk("jmp_dir", dn_if.jmpDir, 10'h155);
        chk("jmp_inm", dn_if.inm, 8'h55);
        chk("jmp_wr", dn_if.wrEnable, 0);
        step();
        chk("jmp_squashed", dn_if.outValid, 0);
        up_if.in = 16'h0800;
        step();
        up_if.inValid = 1'b0;
        chk("jmp_after_valid", dn_if.outValid, 1);
        chk("jmp_after_opc", dn_if.opCode, 6'b000010);
        step();

        // branch on flagA[1], taken
        up_if.in = {6'b110101, 10'h02A};
        up_if.flagA = 3'b010;
        up_if.inValid = 1'b1;
        step();
        up_if.in = 16'h0400;
        up_if.flagA = 3'b000;
        chk("brt_en", dn_if.branchEnable, 1);
        chk("brt_dir", dn_if.branchDir, 6'h2A);
        chk("brt_valid", dn_if.outValid, 1);
        step();
        chk("brt_squashed", dn_if.outValid, 0);
        // branch not taken
        up_if.in = {6'b110101, 10'h015};
        step();
        up_if.in = 16'h0800;
        chk("brn_en", dn_if.branchEnable, 0);
        chk("brn_valid", dn_if.outValid, 1);
        step();
        up_if.inValid = 1'b0;
        chk("brn_next_valid", dn_if.outValid, 1);
        chk("brn_next_opc", dn_if.opCode, 6'b000010);
        step();

        // backpressure stream of 6 with outReady 1,0,0,1
        for (int c = 0; c < 60 && rx < 6; c++) begin
            dn_if.outReady = pat[c % 4];
            up_if.inValid  = (tx < 6);
            up_if.in       = {6'(tx), 10'(tx + 32)};
            if (up_if.inValid && !up_if.inReady) saw_stall = 1'b1;
            if (dn_if.outValid && dn_if.outReady) begin
                chk("bp_opc", dn_if.opCode, 32'(rx));
                chk("bp_dir", dn_if.jmpDir, 32'(rx + 32));
                rx++;
            end
            if (up_if.inValid && up_if.inReady) tx++;
            step();
        end
        up_if.inValid  = 1'b0;
        dn_if.outReady = 1'b1;
        chk("bp_count", 32'(rx), 6);
        chk("bp_stall", saw_stall, 1);
        step();
        step();
        chk("bp_no_dup", dn_if.outValid, 0);

        // output hold under backpressure
        dn_if.outReady = 1'b0;
        up_if.in = 16'h0C00;
        up_if.inValid = 1'b1;
        step();
        up_if.inValid = 1'b0;
        chk("hold1_valid", dn_if.outValid, 1);
        step();
        chk("hold2_valid", dn_if.outValid, 1);
        chk("hold2_opc", dn_if.opCode, 6'b000011);
        dn_if.outReady = 1'b1;
        step();
        chk("hold_drain", dn_if.outValid, 0);

        // illegal: branch index 3 with NF=3, flags all set
        up_if.in = {6'b110111, 10'h000};
        up_if.flagA = 3'b111;
        up_if.flagB = 3'b111;
        up_if.inValid = 1'b1;
        step();
        up_if.in = {6'b111101, 10'h000};
        chk("ill_valid", dn_if.outValid, 1);
        chk("ill_br", dn_if.branchEnable, 0);
        chk("ill_jmp", dn_if.jmpEnable, 0);
        chk("ill_wr", dn_if.wrEnable, 0);
`ifdef DECODEC_TRAP_EN
        chk("ill_flag", dn_if.illegal, 1);
`endif
        // illegal NOP variant; must not squash the follower either
        step();
        up_if.in = {6'b111100, 10'h000};
        chk("illnop_valid", dn_if.outValid, 1);
        chk("illnop_br", dn_if.branchEnable, 0);
        step();
        up_if.inValid = 1'b0;
        chk("nop_valid", dn_if.outValid, 1);
        chk("nop_opc", dn_if.opCode, 6'b111100);
`ifdef DECODEC_TRAP_EN
        chk("nop_flag", dn_if.illegal, 0);
`endif
        step();

        // branch on flagB[1] taken, then reset while counter is 1
        up_if.in = {6'b111001, 10'h000};
        up_if.flagA = 3'b000;
        up_if.flagB = 3'b010;
        up_if.inValid = 1'b1;
        step();
        up_if.inValid = 1'b0;
        chk("brb_en", dn_if.branchEnable, 1);
        chk("brb_valid", dn_if.outValid, 1);
        reset = 1'b0;
        #1;
        chk("rmid_valid", dn_if.outValid, 0);
        chk("rmid_br", dn_if.branchEnable, 0);
        chk("rmid_ready", up_if.inReady, 0);
        step();
        reset = 1'b1;
        step();
        chk("rmid_rel_ready", up_if.inReady, 1);
        up_if.in = 16'h0800;
        up_if.inValid = 1'b1;
        step();
        up_if.inValid = 1'b0;
        chk("rmid_next_valid", dn_if.outValid, 1);
        chk("rmid_next_opc", dn_if.opCode, 6'b000010);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
